// File: rtl/inst_enc_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_enc_if
//  Description : Host load port and issue port bundle for the instruction
//                encoder; the master drives fields, the slave packs and issues.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_enc_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               I_start;
    logic               I_valid;
    logic               O_ready;
    logic               I_last;
    logic               I_fmt;
    logic [4:0]         I_op;
    logic [2:0]         I_selA;
    logic [2:0]         I_selB;
    logic [2:0]         I_selD;
    logic [7:0]         I_imm;
    logic [15:0]        O_inst;
    logic               O_valid;
    logic               I_ready;
    logic [ADDR_W-1:0]  O_addr;
    logic [c_CNT_W-1:0] O_count;
    logic               O_done;
    logic               O_err;

    modport master (
        output I_start, I_valid, I_last, I_fmt, I_op, I_selA, I_selB, I_selD,
               I_imm, I_ready,
        input  O_ready, O_inst, O_valid, O_addr, O_count, O_done, O_err
    );

    modport slave (
        input  I_start, I_valid, I_last, I_fmt, I_op, I_selA, I_selB, I_selD,
               I_imm, I_ready,
        output O_ready, O_inst, O_valid, O_addr, O_count, O_done, O_err
    );
endinterface
`default_nettype wire

// File: rtl/inst_enc.sv
`default_nettype none
// ============================================================================
//  Module      : inst_enc
//  Description : Packs field-level instructions into 16-bit words, buffers
//                them in a FIFO and issues them with a running address.
//                Define INST_ENC_OPCHECK_EN to drop opcodes 5'b1111x and
//                flag them on O_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_enc #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic       I_clk,
    input  logic       I_rst,
    inst_enc_if.slave  bus
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         mem_q [DEPTH];
    logic [15:0]         mem_d [DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         inst_q, inst_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [15:0]         w_packed;
    logic                w_illegal;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    assign w_packed = bus.I_fmt ? {bus.I_op, bus.I_selA, bus.I_imm}
                                : {bus.I_op, bus.I_selA, bus.I_selB, bus.I_selD, 2'b00};

`ifdef INST_ENC_OPCHECK_EN
    assign w_illegal = (bus.I_op[4:1] == 4'b1111);
`else
    assign w_illegal = 1'b0;
`endif

    // An illegal set still completes its handshake; it just never lands in the FIFO.
    assign w_accept = bus.I_valid && ready_q;
    assign w_push   = w_accept && !w_illegal;
    assign w_pop    = valid_q && bus.I_ready;

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        done_d   = 1'b0;

        if (w_push) begin
            mem_d[wr_ptr_q] = w_packed;
            wr_ptr_d        = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (w_accept && w_illegal) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.I_start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (w_accept && bus.I_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from next-state values so every port is a flop.
        ready_d = (state_d == LOAD) && (count_d < c_DEPTH);
        valid_d = (count_d != '0);
        inst_d  = (w_push && (rd_ptr_d == wr_ptr_q)) ? w_packed : mem_q[rd_ptr_d];
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q  <= IDLE;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.O_ready = ready_q;
    assign bus.O_inst  = inst_q;
    assign bus.O_valid = valid_q;
    assign bus.O_addr  = addr_q;
    assign bus.O_count = count_q;
    assign bus.O_done  = done_q;
`ifdef INST_ENC_OPCHECK_EN
    assign bus.O_err   = err_q;
`else
    assign bus.O_err   = 1'b0;
`endif

endmodule
`default_nettype wire
